// File: rtl/wb_pipe_multi.sv
// wb_pipe_multi: multi-channel, multi-stage MEM->WB write-back pipeline register.
//
// Carries NCH register-write channels through STAGES delay stages between the
// memory stage and the register file.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   stall        pipeline stall vector (only ME_IDX and WB_IDX are used)
//   flush        synchronous clear of every stage, overrides stall
//   me_w_*       per-channel write requests from the memory stage
//   wb_w_*       per-channel writes leaving the final stage
//   fwd_r_addr   forwarding query address
//   fwd_hit      query matched an in-flight write
//   fwd_data     forwarded data, zero on a miss
//   inflight     number of valid entries across all stages (registered)
//
// Channel c of every packed bus sits at [c*W +: W].

module wb_pipe_multi #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NCH     = 2,
    parameter int STAGES  = 2,
    parameter int STALL_W = 6,
    parameter int ME_IDX  = 4,
    parameter int WB_IDX  = 5,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [NCH-1:0]        me_w_enable,
    input  logic [NCH*ADDR_W-1:0] me_w_addr,
    input  logic [NCH*DATA_W-1:0] me_w_data,
    output logic [NCH-1:0]        wb_w_enable,
    output logic [NCH*ADDR_W-1:0] wb_w_addr,
    output logic [NCH*DATA_W-1:0] wb_w_data,
    input  logic [ADDR_W-1:0]     fwd_r_addr,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      inflight
);

    // Stage 0 is the youngest; stage STAGES-1 drives the wb_* outputs.
    logic [STAGES-1:0][NCH-1:0]             en_q,   en_d;
    logic [STAGES-1:0][NCH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [STAGES-1:0][NCH-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]                       inflight_q, inflight_d;

    logic [NCH-1:0][ADDR_W-1:0] me_addr_v;
    logic [NCH-1:0]             cap_en;

    // Only two stall bits matter here; the rest of the vector is folded away.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign me_addr_v = me_w_addr;

    // Capture filter: x0 writes never become valid, and when two channels
    // target the same register in one cycle the higher index wins, matching
    // program order within a dual-issue bundle.
    always_comb begin
        cap_en = '0;
        for (int c = 0; c < NCH; c++) begin
            cap_en[c] = me_w_enable[c] && (me_addr_v[c] != '0);
            for (int j = c + 1; j < NCH; j++) begin
                if (me_w_enable[j] && (me_addr_v[j] == me_addr_v[c])) begin
                    cap_en[c] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        data_d = data_q;

        if (flush) begin
            en_d   = '0;
            addr_d = '0;
            data_d = '0;
        end else if (!stall[WB_IDX]) begin
            for (int s = 1; s < STAGES; s++) begin
                en_d[s]   = en_q[s-1];
                addr_d[s] = addr_q[s-1];
                data_d[s] = data_q[s-1];
            end
            if (stall[ME_IDX]) begin
                en_d[0]   = '0;
                addr_d[0] = '0;
                data_d[0] = '0;
            end else begin
                en_d[0]   = cap_en;
                addr_d[0] = me_w_addr;
                data_d[0] = me_w_data;
            end
        end

        inflight_d = '0;
        for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < NCH; c++) begin
                inflight_d = inflight_d + CNT_W'(en_d[s][c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            inflight_q <= '0;
        end else begin
            en_q       <= en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            inflight_q <= inflight_d;
        end
    end

    // Forwarding: scan oldest-to-youngest and low-to-high channel so the last
    // match written (youngest stage, highest channel) takes priority.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            for (int c = 0; c < NCH; c++) begin
                if (en_q[s][c] && (addr_q[s][c] == fwd_r_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[s][c];
                end
            end
        end
        if (fwd_r_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

    assign wb_w_enable = en_q[STAGES-1];
    assign wb_w_addr   = addr_q[STAGES-1];
    assign wb_w_data   = data_q[STAGES-1];
    assign inflight    = inflight_q;

endmodule

// File: tb/tb_wb_pipe_multi.sv
module tb_wb_pipe_multi;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  me_w_enable;
    logic [9:0]  me_w_addr;
    logic [63:0] me_w_data;
    logic [1:0]  wb_w_enable;
    logic [9:0]  wb_w_addr;
    logic [63:0] wb_w_data;
    logic [4:0]  fwd_r_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  inflight;

    int checks;
    int failures;

    wb_pipe_multi dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .me_w_enable (me_w_enable),
        .me_w_addr   (me_w_addr),
        .me_w_data   (me_w_data),
        .wb_w_enable (wb_w_enable),
        .wb_w_addr   (wb_w_addr),
        .wb_w_data   (wb_w_data),
        .fwd_r_addr  (fwd_r_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .inflight    (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        me_w_enable = en;
        me_w_addr   = {a1, a0};
        me_w_data   = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall = '0;
        flush = 1'b0;
        idle();
        fwd_r_addr = 5'd3;
        #12;
        checks++; if (wb_w_enable !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", wb_w_enable); end
        checks++; if (wb_w_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", wb_w_addr); end
        checks++; if (wb_w_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_w_data); end
        checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin failures++; $display("FAIL reset_fwd got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        drive(2'b11, 5'd3, 32'hA5, 5'd7, 32'h5A);
        tick();
        idle();
        fwd_r_addr = 5'd7;
        #1;
        checks++; if (wb_w_enable !== 2'b00) begin failures++; $display("FAIL basic_e1_en got=%b exp=00", wb_w_enable); end
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h5A) begin failures++; $display("FAIL basic_fwd7 got=%b/%h exp=1/5a", fwd_hit, fwd_data); end
        checks++; if (inflight !== 4'd2) begin failures++; $display("FAIL basic_e1_inflight got=%0d exp=2", inflight); end
        fwd_r_addr = 5'd3;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hA5) begin failures++; $display("FAIL basic_fwd3 got=%b/%h exp=1/a5", fwd_hit, fwd_data); end
        tick();
        checks++; if (wb_w_enable !== 2'b11) begin failures++; $display("FAIL basic_e2_en got=%b exp=11", wb_w_enable); end
        checks++; if (wb_w_addr !== {5'd7, 5'd3}) begin failures++; $display("FAIL basic_e2_addr got=%h exp=%h", wb_w_addr, {5'd7, 5'd3}); end
        checks++; if (wb_w_data !== {32'h5A, 32'hA5}) begin failures++; $display("FAIL basic_e2_data got=%h exp=%h", wb_w_data, {32'h5A, 32'hA5}); end
        checks++; if (inflight !== 4'd2) begin failures++; $display("FAIL basic_e2_inflight got=%0d exp=2", inflight); end
        tick();
        checks++; if (wb_w_enable !== 2'b00 || inflight !== 4'd0) begin failures++; $display("FAIL basic_drain got=%b/%0d exp=00/0", wb_w_enable, inflight); end
    endtask

    task automatic test_me_stall();
        drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
        tick();
        stall = 6'b010000;
        drive(2'b10, 5'd0, 32'h0, 5'd8, 32'h88);
        tick();
        stall = '0;
        idle();
        fwd_r_addr = 5'd8;
        #1;
        checks++; if (wb_w_enable !== 2'b01) begin failures++; $display("FAIL mestall_en got=%b exp=01", wb_w_enable); end
        checks++; if (wb_w_addr[4:0] !== 5'd4 || wb_w_data[31:0] !== 32'h44) begin failures++; $display("FAIL mestall_wb got=%h/%h exp=4/44", wb_w_addr[4:0], wb_w_data[31:0]); end
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL mestall_inflight got=%0d exp=1", inflight); end
        checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL mestall_bubble got=%b exp=0", fwd_hit); end
        tick();
        checks++; if (wb_w_enable !== 2'b00 || inflight !== 4'd0) begin failures++; $display("FAIL mestall_drain got=%b/%0d exp=00/0", wb_w_enable, inflight); end
    endtask

    task automatic test_wb_stall();
        drive(2'b11, 5'd10, 32'h10, 5'd11, 32'h11);
        tick();
        drive(2'b01, 5'd12, 32'h12, 5'd0, 32'h0);
        tick();
        checks++; if (wb_w_enable !== 2'b11 || inflight !== 4'd3) begin failures++; $display("FAIL wbstall_pre got=%b/%0d exp=11/3", wb_w_enable, inflight); end
        stall = 6'b110000;
        drive(2'b10, 5'd0, 32'h0, 5'd13, 32'h13);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wb_w_enable !== 2'b11 || wb_w_addr !== {5'd11, 5'd10} || wb_w_data !== {32'h11, 32'h10} || inflight !== 4'd3) begin
                failures++;
                $display("FAIL wbstall_hold%0d got=%b/%h/%h/%0d exp=11/%h/%h/3", i, wb_w_enable, wb_w_addr, wb_w_data, inflight, {5'd11, 5'd10}, {32'h11, 32'h10});
            end
        end
        stall = '0;
        idle();
        tick();
        checks++; if (wb_w_enable !== 2'b01 || wb_w_addr[4:0] !== 5'd12 || wb_w_data[31:0] !== 32'h12) begin failures++; $display("FAIL wbstall_resume got=%b/%h/%h exp=01/c/12", wb_w_enable, wb_w_addr[4:0], wb_w_data[31:0]); end
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL wbstall_resume_inflight got=%0d exp=1", inflight); end
        tick();
    endtask

    task automatic test_conflict();
        drive(2'b11, 5'd9, 32'h11, 5'd9, 32'h22);
        tick();
        drive(2'b01, 5'd0, 32'h33, 5'd0, 32'h0);
        fwd_r_addr = 5'd9;
        #1;
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL conflict_inflight got=%0d exp=1", inflight); end
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin failures++; $display("FAIL conflict_fwd got=%b/%h exp=1/22", fwd_hit, fwd_data); end
        tick();
        idle();
        checks++; if (wb_w_enable !== 2'b10 || wb_w_addr[9:5] !== 5'd9 || wb_w_data[63:32] !== 32'h22) begin failures++; $display("FAIL conflict_wb got=%b/%h/%h exp=10/9/22", wb_w_enable, wb_w_addr[9:5], wb_w_data[63:32]); end
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL x0_inflight got=%0d exp=1", inflight); end
        tick();
        checks++; if (wb_w_enable !== 2'b00 || inflight !== 4'd0) begin failures++; $display("FAIL x0_wb got=%b/%0d exp=00/0", wb_w_enable, inflight); end
    endtask

    task automatic test_fwd_priority();
        drive(2'b01, 5'd5, 32'h1, 5'd0, 32'h0);
        tick();
        drive(2'b10, 5'd0, 32'h0, 5'd5, 32'h2);
        tick();
        idle();
        fwd_r_addr = 5'd5;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin failures++; $display("FAIL fwd_young got=%b/%h exp=1/2", fwd_hit, fwd_data); end
        fwd_r_addr = 5'd0;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin failures++; $display("FAIL fwd_x0 got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        fwd_r_addr = 5'd6;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin failures++; $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit, fwd_data); end
        fwd_r_addr = 5'd5;
        tick();
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2) begin failures++; $display("FAIL fwd_older got=%b/%h exp=1/2", fwd_hit, fwd_data); end
        tick();
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin failures++; $display("FAIL fwd_empty got=%b/%h exp=0/0", fwd_hit, fwd_data); end
    endtask

    task automatic test_flush();
        drive(2'b11, 5'd1, 32'hF1, 5'd2, 32'hF2);
        tick();
        drive(2'b01, 5'd3, 32'hF3, 5'd0, 32'h0);
        tick();
        idle();
        checks++; if (inflight !== 4'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", inflight); end
        flush = 1'b1;
        stall = 6'b100000;
        tick();
        flush = 1'b0;
        stall = '0;
        checks++; if (wb_w_enable !== 2'b00 || inflight !== 4'd0) begin failures++; $display("FAIL flush_clear got=%b/%0d exp=00/0", wb_w_enable, inflight); end
        checks++; if (wb_w_addr !== 10'd0 || wb_w_data !== 64'd0) begin failures++; $display("FAIL flush_bubble got=%h/%h exp=0/0", wb_w_addr, wb_w_data); end
    endtask

    task automatic test_async_reset();
        drive(2'b11, 5'd20, 32'hC0, 5'd21, 32'hC1);
        tick();
        drive(2'b01, 5'd22, 32'hC2, 5'd0, 32'h0);
        tick();
        idle();
        fwd_r_addr = 5'd22;
        checks++; if (inflight !== 4'd3 || wb_w_enable !== 2'b11) begin failures++; $display("FAIL arst_pre got=%b/%0d exp=11/3", wb_w_enable, inflight); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (wb_w_enable !== 2'b00 || wb_w_addr !== 10'd0 || wb_w_data !== 64'd0) begin failures++; $display("FAIL arst_wb got=%b/%h/%h exp=00/0/0", wb_w_enable, wb_w_addr, wb_w_data); end
        checks++; if (inflight !== 4'd0 || fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin failures++; $display("FAIL arst_state got=%0d/%b/%h exp=0/0/0", inflight, fwd_hit, fwd_data); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (wb_w_enable !== 2'b00 || inflight !== 4'd0) begin failures++; $display("FAIL arst_after got=%b/%0d exp=00/0", wb_w_enable, inflight); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_me_stall();
        test_wb_stall();
        test_conflict();
        test_fwd_priority();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
